// File: rtl/soft_mute_pkg.sv
// Shared types and the next-gain rule for the soft mute ramp.
// The rule is written against a fixed 32-bit gain so any RAMP_LOG2 up to 30 can use it.
package soft_mute_pkg;

    typedef enum logic [1:0] {
        MUTED     = 2'd0,
        RAMP_UP   = 2'd1,
        UNMUTED   = 2'd2,
        RAMP_DOWN = 2'd3
    } mute_state_t;

    localparam int GAIN_ARG_W = 32;

    typedef struct packed {
        mute_state_t             state;
        logic [GAIN_ARG_W-1:0]   gain;
    } gain_step_t;

    function automatic gain_step_t next_gain(
        input mute_state_t           state,
        input logic [GAIN_ARG_W-1:0] gain,
        input logic                  mute_req,
        input logic                  ramp_en,
        input logic [GAIN_ARG_W-1:0] full
    );
        gain_step_t step;
        step.state = state;
        step.gain  = gain;
        case (state)
            UNMUTED: begin
                if (mute_req) begin
                    if (ramp_en) begin
                        step.gain  = full - 1;
                        step.state = (step.gain == '0) ? MUTED : RAMP_DOWN;
                    end else begin
                        step.gain  = '0;
                        step.state = MUTED;
                    end
                end
            end
            MUTED: begin
                if (!mute_req) begin
                    if (ramp_en) begin
                        step.gain  = 1;
                        step.state = (step.gain == full) ? UNMUTED : RAMP_UP;
                    end else begin
                        step.gain  = full;
                        step.state = UNMUTED;
                    end
                end
            end
            RAMP_DOWN, RAMP_UP: begin
                // Reversal steps from the current gain, so the waveform never jumps.
                if (!ramp_en) begin
                    step.gain  = mute_req ? '0 : full;
                    step.state = mute_req ? MUTED : UNMUTED;
                end else if (mute_req) begin
                    step.gain  = gain - 1;
                    step.state = (step.gain == '0) ? MUTED : RAMP_DOWN;
                end else begin
                    step.gain  = gain + 1;
                    step.state = (step.gain == full) ? UNMUTED : RAMP_UP;
                end
            end
            default: begin
                step.gain  = '0;
                step.state = MUTED;
            end
        endcase
        return step;
    endfunction

endpackage

// File: rtl/sm_gain_mult.sv
// Single-channel signed sample times unsigned gain, floor-shifted back to sample width.
module sm_gain_mult #(
    parameter int DATA_W    = 32,
    parameter int RAMP_LOG2 = 8
) (
    input  logic [DATA_W-1:0]    sample,
    input  logic [RAMP_LOG2:0]   gain,
    output logic [DATA_W-1:0]    scaled
);

    localparam int PROD_W = DATA_W + RAMP_LOG2 + 1;

    logic signed [PROD_W-1:0] sample_ext;
    logic signed [PROD_W-1:0] gain_ext;
    logic signed [PROD_W-1:0] product;
    logic signed [PROD_W-1:0] shifted;

    // gain <= FULL keeps the product inside PROD_W, so truncation after the shift is lossless.
    always_comb begin
        sample_ext = {{(PROD_W-DATA_W){sample[DATA_W-1]}}, sample};
        gain_ext   = {{(PROD_W-RAMP_LOG2-1){1'b0}}, gain};
        product    = sample_ext * gain_ext;
        shifted    = product >>> RAMP_LOG2;
        scaled     = shifted[DATA_W-1:0];
    end

endmodule

// File: rtl/soft_mute_ramp.sv
// Click-free mute: one shared gain ramps linearly between 0 and FULL across NUM_CH channels.
module soft_mute_ramp
    import soft_mute_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int NUM_CH    = 2,
    parameter int RAMP_LOG2 = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mute_req,
    input  logic                     ramp_en,
    input  logic                     in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic                     out_valid,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic                     muted,
    output logic                     ramping
);

    localparam logic [GAIN_ARG_W-1:0] FULL = GAIN_ARG_W'(1) << RAMP_LOG2;

    mute_state_t                state;
    logic [RAMP_LOG2:0]         gain;
    gain_step_t                 step;
    logic [NUM_CH*DATA_W-1:0]   scaled;
    logic                       unused_step_bits;

    always_comb begin
        step = next_gain(state, GAIN_ARG_W'(gain), mute_req, ramp_en, FULL);
    end

    assign unused_step_bits = ^step.gain[GAIN_ARG_W-1:RAMP_LOG2+1];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        sm_gain_mult #(
            .DATA_W    (DATA_W),
            .RAMP_LOG2 (RAMP_LOG2)
        ) u_mult (
            .sample (in_data[c*DATA_W +: DATA_W]),
            .gain   (gain),
            .scaled (scaled[c*DATA_W +: DATA_W])
        );
    end

    // The frame is scaled by the current gain; the gain step lands for the following frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= MUTED;
            gain      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            muted     <= 1'b1;
            ramping   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= scaled;
                state    <= step.state;
                gain     <= step.gain[RAMP_LOG2:0];
                muted    <= (step.state == MUTED);
                ramping  <= (step.state == RAMP_UP) || (step.state == RAMP_DOWN);
            end
        end
    end

endmodule

// File: tb/tb_soft_mute_ramp.sv
// Self-checking bench for soft_mute_ramp with DATA_W=32, NUM_CH=2, RAMP_LOG2=2.
module tb_soft_mute_ramp;

    localparam int DATA_W    = 32;
    localparam int NUM_CH    = 2;
    localparam int RAMP_LOG2 = 2;
    localparam int FULL      = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mute_req;
    logic        ramp_en;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_valid;
    logic [63:0] out_data;
    logic        muted;
    logic        ramping;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    int          m_gain   = 0;
    logic        exp_valid = 1'b0;
    logic [63:0] exp_data  = '0;

    always #5 clk = ~clk;

    soft_mute_ramp #(
        .DATA_W    (DATA_W),
        .NUM_CH    (NUM_CH),
        .RAMP_LOG2 (RAMP_LOG2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mute_req  (mute_req),
        .ramp_en   (ramp_en),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .muted     (muted),
        .ramping   (ramping)
    );

    // Exact floor(x * g / FULL) via integer division rather than shifts.
    function automatic int scale(input int x, input int g);
        longint p;
        p = longint'(x) * longint'(g);
        if (p >= 0)
            return int'(p / FULL);
        return int'(-((-p + FULL - 1) / FULL));
    endfunction

    // Model: the gain walks one step toward its target per frame, or jumps when ramping is off.
    always @(posedge clk) begin
        int target;
        if (reset) begin
            m_gain    = 0;
            exp_valid = 1'b0;
            exp_data  = '0;
        end else begin
            exp_valid = in_valid;
            if (in_valid) begin
                for (int c = 0; c < NUM_CH; c++)
                    exp_data[c*32 +: 32] = scale($signed(in_data[c*32 +: 32]), m_gain);
                target = mute_req ? 0 : FULL;
                if (!ramp_en)             m_gain = target;
                else if (m_gain < target) m_gain = m_gain + 1;
                else if (m_gain > target) m_gain = m_gain - 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkLane(input string name, input int ch, input int exp);
        checkOutput(name, {32'b0, out_data[ch*32 +: 32]}, {32'b0, exp});
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cyc_out_valid", {63'b0, out_valid}, {63'b0, exp_valid});
            checkOutput("cyc_out_data", out_data, exp_data);
            checkOutput("cyc_muted", {63'b0, muted}, {63'b0, (m_gain == 0)});
            checkOutput("cyc_ramping", {63'b0, ramping}, {63'b0, (m_gain > 0 && m_gain < FULL)});
        end
    end

    task automatic applyStimulus(input logic mreq, input logic ren, input logic vld,
                                 input int l, input int r);
        @(negedge clk);
        mute_req = mreq;
        ramp_en  = ren;
        in_valid = vld;
        in_data  = {r, l};
        @(posedge clk);
        #1;
    endtask

    int t1_l[6]  = '{0, 250, 500, 750, 1000, 1000};
    int t2_l[5]  = '{1000, 750, 500, 250, 0};
    int t2_r[5]  = '{-1001, -751, -501, -251, 0};
    logic t3_m[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int t3_l[5]  = '{1000, 750, 500, 750, 1000};
    int t5_l[4]  = '{1000, 750, 500, 250};
    int fl_l[4]  = '{0, 1, 3, 5};
    int fl_r[4]  = '{0, -2, -4, -6};
    int min_val;

    initial begin
        min_val  = 32'sh8000_0000;
        reset    = 1'b1;
        mute_req = 1'b0;
        ramp_en  = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_muted", {63'b0, muted}, 64'd1);
        checkOutput("rst_ramping", {63'b0, ramping}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // Power-up ramp from silence.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1000, -1000);
            checkLane("t1_left", 0, t1_l[i]);
            checkLane("t1_right", 1, -t1_l[i]);
            checkOutput("t1_ramping", {63'b0, ramping}, {63'b0, (i < 3)});
            if (i == 0) checkOutput("t1_muted_fall", {63'b0, muted}, 64'd0);
        end

        // Ramp down with floor rounding on the negative channel.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1000, -1001);
            checkLane("t2_left", 0, t2_l[i]);
            checkLane("t2_right", 1, t2_r[i]);
        end
        checkOutput("t2_muted", {63'b0, muted}, 64'd1);

        repeat (4) applyStimulus(1'b0, 1'b1, 1'b1, 0, 0);
        checkOutput("unmuted_reached", {63'b0, muted | ramping}, 64'd0);

        // Reversal mid-ramp.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(t3_m[i], 1'b1, 1'b1, 1000, 0);
            checkLane("t3_left", 0, t3_l[i]);
        end
        checkOutput("t3_end_ramping", {63'b0, ramping}, 64'd0);
        checkOutput("t3_end_muted", {63'b0, muted}, 64'd0);

        // Hard mute mode.
        applyStimulus(1'b1, 1'b0, 1'b1, 1000, 1000);
        checkLane("t4_first", 0, 1000);
        applyStimulus(1'b1, 1'b0, 1'b1, 1000, 1000);
        checkLane("t4_silent", 0, 0);
        checkOutput("t4_muted", {63'b0, muted}, 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1000, 1000);
        checkLane("t4_release0", 0, 0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1000, 1000);
        checkLane("t4_release1", 0, 1000);

        // Sparse valid frames during a ramp.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 1000, 0);
            checkLane("t5_left", 0, t5_l[i]);
            checkOutput("t5_valid", {63'b0, out_valid}, 64'd1);
            for (int k = 0; k < 2; k++) begin
                applyStimulus(1'b1, 1'b1, 1'b0, 555, 0);
                checkOutput("t5_gap_valid", {63'b0, out_valid}, 64'd0);
                checkLane("t5_hold", 0, t5_l[i]);
            end
        end

        // ramp_en dropped mid-ramp jumps straight to target.
        applyStimulus(1'b0, 1'b1, 1'b1, 400, 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 400, 0);
        checkLane("jump_up_pre", 0, 100);
        applyStimulus(1'b0, 1'b0, 1'b1, 400, 0);
        checkLane("jump_up_frame", 0, 200);
        checkOutput("jump_up_state", {62'b0, muted, ramping}, 64'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 400, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 400, 0);
        checkLane("jump_down_frame", 0, 300);
        checkOutput("jump_down_muted", {63'b0, muted}, 64'd1);

        // Small values pin the floor behaviour.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 7, -7);
            checkLane("floor_left", 0, fl_l[i]);
            checkLane("floor_right", 1, fl_r[i]);
        end

        // Full-scale negative passes through untouched at unity gain.
        applyStimulus(1'b1, 1'b1, 1'b1, min_val, min_val);
        checkLane("min_left", 0, min_val);
        checkLane("min_right", 1, min_val);
        applyStimulus(1'b1, 1'b1, 1'b1, 1000, 0);
        checkOutput("pre_reset_ramping", {63'b0, ramping}, 64'd1);

        // Reset mid ramp-down.
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midramp_rst_data", out_data, 64'd0);
        checkOutput("midramp_rst_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("midramp_rst_muted", {63'b0, muted}, 64'd1);
        checkOutput("midramp_rst_ramping", {63'b0, ramping}, 64'd0);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/soft_mute_ramp.md
Name: soft_mute_ramp

Overview:
Parametrised, click-free successor to the stereo hard-mute effect. It sits in the per-sample effect chain and applies one common gain to NUM_CH channels, one sample frame at a time. On a mute request the gain ramps linearly from unity to zero over 2^RAMP_LOG2 frames, and it ramps back up on release. A ramp_en mode input restores instant hard-mute behaviour.

Parameters:
DATA_W, 32, signed sample width per channel
NUM_CH, 2, channels per frame; all channels share one gain
RAMP_LOG2, 8, ramp length is FULL = 2^RAMP_LOG2 frames; gain range is 0..FULL

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
mute_req  in  1  level input; 1 = mute requested
ramp_en  in  1  1 = linear ramp; 0 = hard gain jump
in_valid  in  1  one frame presented this cycle
in_data  in  NUM_CH*DATA_W  packed signed samples; channel c occupies bits [c*DATA_W +: DATA_W]
out_valid  out  1  registered copy of in_valid
out_data  out  NUM_CH*DATA_W  scaled samples, same packing as in_data
muted  out  1  high when state is MUTED
ramping  out  1  high when state is RAMP_DOWN or RAMP_UP

Behaviour:
- Reset: gain=0, state=MUTED, out_valid=0, out_data=0, muted=1, ramping=0. The block powers up silent; if mute_req=0 it ramps up (no pop). Reset mid-ramp aborts the ramp with the same values.
- Latency is 1 cycle, with no backpressure. out_valid(t+1)=in_valid(t). out_data updates only when in_valid=1 and holds otherwise.
- Arithmetic, per channel:
  - out = (in * $signed({1'b0,gain})) >>> RAMP_LOG2, using an arithmetic (floor) shift.
  - The product is DATA_W+RAMP_LOG2+1 bits wide. The result is truncated to DATA_W and never overflows, because gain ≤ FULL.
  - gain=FULL is exact passthrough, including -2^(DATA_W-1). gain=0 gives exact zero.
- Gain timing:
  - A frame accepted at cycle t is scaled by the gain register value at t.
  - The gain update happens at t+1 and therefore affects the next frame.
  - Gain and state change only on in_valid cycles. mute_req and ramp_en are sampled only on in_valid cycles.
- State machine: target = mute_req ? 0 : FULL.
  - UNMUTED (gain=FULL): if mute_req, go to RAMP_DOWN with gain FULL-1 when ramp_en=1, or to MUTED with gain 0 when ramp_en=0.
  - RAMP_DOWN: if mute_req=0, go to RAMP_UP with gain+1. Otherwise gain-1; reaching 0 goes to MUTED.
  - MUTED (gain=0): if mute_req=0, go to RAMP_UP with gain 1 when ramp_en=1, or to UNMUTED with gain FULL when ramp_en=0.
  - RAMP_UP: if mute_req=1, go to RAMP_DOWN with gain-1. Otherwise gain+1; reaching FULL goes to UNMUTED.
  - In either ramp state, ramp_en=0 jumps the gain directly to target and moves to MUTED or UNMUTED.
- Reversal mid-ramp continues from the current gain, with no discontinuity. Gain never leaves 0..FULL.
- muted and ramping are decoded from registered state and change in the cycle after the deciding frame.

Decomposition:
- Package soft_mute_pkg holds:
  - enum mute_state_t {MUTED, RAMP_UP, UNMUTED, RAMP_DOWN}
  - function next_gain(state, gain, mute_req, ramp_en, FULL) returning the next state and gain.
- One sub-module, sm_gain_mult (DATA_W, RAMP_LOG2), holds the signed×unsigned multiply and shift for a single channel. It is purely combinational and instantiated NUM_CH times in a generate loop. The output register lives in the top level.

Test Plan:
All scenarios use DATA_W=32, NUM_CH=2, RAMP_LOG2=2 (FULL=4), ramp_en=1 unless stated.
1. Reset, then mute_req=0 and 6 valid frames of L=1000, R=-1000 -> out L 0,250,500,750,1000,1000 (R negated). muted falls after frame 1; ramping is high while gain is 1..3.
2. From UNMUTED, mute_req=1 for 5 frames of L=1000, R=-1001 -> L 1000,750,500,250,0; R -1001,-751,-501,-251,0 (floor shift). muted=1 after frame 5.
3. From UNMUTED: mute_req=1 for 2 frames, then 0 for 3 frames, with L=1000 -> 1000,750,500,750,1000. State ends UNMUTED with no jump.
4. ramp_en=0: mute_req rises on frame k with L=1000 -> frame k=1000, frame k+1=0. On release, the first frame out is 0 and the next is 1000.
5. in_valid gaps (valid every 3rd cycle) during a ramp -> gain steps once per valid frame only; out_valid mirrors in_valid delayed by 1 cycle; out_data holds between frames.
6. At UNMUTED: in=-2^31 -> out exactly -2^31. Then assert reset mid RAMP_DOWN -> next cycle out_data=0, out_valid=0, muted=1, ramping=0.
